mmm_serial: RTL and testbench
=============================

# mmm_serial

Bit-serial Montgomery modular multiplier, the datapath responder driven by the RSA exponentiation control FSM over the `rst_mmm`/`ld_a` interface. It computes R = A·B·2^-WIDTH mod M in a fixed WIDTH+2 cycles. It presents a registered, reduced result that the controller captures with `ld_r`. The block is used for mapping, for each square/multiply round and for the final remap.

## Interface
- `WIDTH`, 8: operand and modulus width in bits; must be ≥ 4.
- `clk`  in  1  system clock, rising edge.
- `rstb`  in  1  asynchronous active-low reset.
- `ena`  in  1  global enable; when 0, all state (FSM, counter, registers, outputs) holds.
- `rst_mmm`  in  1  synchronous active-low clear of the multiplier; has priority over `ld_a`.
- `ld_a`  in  1  start pulse; samples `a_in`, `b_in`, `m_in` and begins a multiplication.
- `a_in`  in  WIDTH  multiplier operand A, with A < M.
- `b_in`  in  WIDTH  multiplicand operand B, with B < M.
- `m_in`  in  WIDTH  modulus M; must be odd, and M > 1.
- `r_out`  out  WIDTH  registered result; reset value 0.
- `busy`  out  1  high while a multiplication is in progress; reset value 0.
- `done`  out  1  high while `r_out` holds a completed result; reset value 0.

## Operation
- Internal registers:
  - `a_sh` (WIDTH), right-shifted each iteration.
  - `b_q` and `m_q` (WIDTH), frozen at start.
  - accumulator `acc` (WIDTH+1).
  - iteration counter `cnt` ($clog2(WIDTH+1) bits).
- FSM states and transitions:
  - IDLE → CALC on `ld_a`.
  - CALC → FINAL when `cnt == WIDTH-1` at the iteration edge.
  - FINAL → DONE unconditionally.
  - DONE → CALC on `ld_a`.
- Reset value of the FSM is IDLE.
- Start (`ld_a`=1, `rst_mmm`=1, `ena`=1, any state):
  - `a_sh`←`a_in`, `b_q`←`b_in`, `m_q`←`m_in`, `acc`←0, `cnt`←0.
  - `done`←0, `busy`←1, state←CALC.
  - `ld_a` in CALC or FINAL aborts the current operation and restarts it; no `done` is produced for the aborted operation.
- CALC iteration, one per enabled clock:
  - t = `acc` + (`a_sh`[0] ? `b_q` : 0), computed WIDTH+2 bits wide.
  - q = t[0].
  - `acc` ← (t + (q ? `m_q` : 0)) >> 1, truncated to WIDTH+1 bits.
  - `a_sh` ← `a_sh` >> 1.
  - `cnt` ← `cnt`+1.
  - Invariant: `acc` < 2M after every iteration, so no overflow occurs.
- FINAL:
  - `r_out` ← (`acc` ≥ M) ? `acc`−M : `acc`, taking the low WIDTH bits.
  - `busy`←0, `done`←1.
- DONE: `r_out` and `done` hold until `ld_a` or `rst_mmm`=0. `ld_a` clears `done` on its sampling edge.
- `rst_mmm`=0 with `ena`=1:
  - state←IDLE; `acc`, `cnt`, `a_sh` ← 0.
  - `busy`←0, `done`←0, `r_out`←0.
  - This applies regardless of `ld_a`.
- `ena`=0 overrides `rst_mmm` and `ld_a`; both are ignored that cycle.
- `rstb` low, at any time including mid-CALC: all registers are cleared to 0 immediately and the FSM goes to IDLE.
- Operands violating the stated preconditions (A ≥ M, B ≥ M, even M) produce an undefined `r_out`. Timing is unaffected.

## Timing
- Number enabled edges from the edge that samples `ld_a` as edge 0.
- Iterations occur on edges 1..WIDTH; FINAL updates `r_out` on edge WIDTH+1.
- Latency: `done`=1 and `r_out` are valid after edge WIDTH+1. This meets a controller that holds `ld_a` one cycle, waits WIDTH+1 cycles, then asserts `ld_r` on the next cycle.
- `busy` is high after edges 0..WIDTH and low after edge WIDTH+1.
- Disabled cycles (`ena`=0) stretch latency one-for-one and do not advance `cnt`.
- A back-to-back `ld_a` on the edge after `done` rises starts a new operation; `done` falls on that edge.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Test plan
- Reset:
  - Assert `rstb`=0 mid-CALC.
  - Required: `r_out`=0, `busy`=0, `done`=0 immediately.
  - After release, the block stays idle until `ld_a`.
- Basic multiply, WIDTH=8, M=13, A=5, B=7, `ld_a` pulsed once:
  - Required: `busy` high for edges 0..8.
  - Required: `done`=1 and `r_out`=1 after edge 9.
- Table check, WIDTH=8, M=13:
  - (12,12)→3; (0,9)→0; (9,9)→9, the fixed point R mod M.
  - M=251, A=B=5 → 5.
  - Random A,B<M: compare against a reference model computing A·B·2^-8 mod M.
- Final subtraction exercised:
  - Sweep all A,B<13 with M=13.
  - Required: every result is < 13 and matches the model, including cases where `acc` ≥ M before FINAL.
- Control interactions:
  - `ld_a` re-pulsed at edge 4 → the result arrives 9 edges after the second pulse and `done` never rises early.
  - `rst_mmm`=0 together with `ld_a`=1 → IDLE with all outputs 0.
  - `ena`=0 for 3 cycles mid-CALC → `done` is delayed exactly 3 cycles and the value is unchanged.
- Hold:
  - After `done`, idle for 20 cycles.
  - Required: `r_out` and `done` stay stable; the next `ld_a` clears `done` on its edge.

Source files
------------

// File: rtl/mmm_serial_if.sv
// Controller <-> Montgomery multiplier handshake: start/clear controls, operands, registered result.
interface mmm_serial_if #(parameter int WIDTH = 8);
  logic             ena;
  logic             rst_mmm;
  logic             ld_a;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] m_in;
  logic [WIDTH-1:0] r_out;
  logic             busy;
  logic             done;

  modport master (output ena, rst_mmm, ld_a, a_in, b_in, m_in,
                  input  r_out, busy, done);
  modport slave  (input  ena, rst_mmm, ld_a, a_in, b_in, m_in,
                  output r_out, busy, done);
endinterface

// File: rtl/mmm_serial.sv
// Bit-serial Montgomery multiplier: R = A*B*2^-WIDTH mod M in WIDTH+2 enabled cycles.
module mmm_serial #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rstb,
  mmm_serial_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FINAL, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             clr, start, last;
  logic [WIDTH+1:0] t, u;
  logic [WIDTH:0]   red;

  // Clear beats start; a disabled cycle ignores both.
  assign clr   = bus.ena & ~bus.rst_mmm;
  assign start = bus.ena &  bus.rst_mmm & bus.ld_a;
  assign last  = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_q     <= b_d;
      m_q     <= m_d;
      r_q     <= r_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr)
      state_d = IDLE;
    else if (start)
      state_d = CALC;
    else if (bus.ena) begin
      case (state_q)
        CALC:    if (last) state_d = FINAL;
        FINAL:   state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    // acc < 2M keeps t and u within WIDTH+2 bits.
    t   = {1'b0, acc_q} + (a_sh_q[0] ? {2'b00, b_q} : '0);
    u   = t + (t[0] ? {2'b00, m_q} : '0);
    red = acc_q - {1'b0, m_q};

    a_sh_d = a_sh_q;
    b_d    = b_q;
    m_d    = m_q;
    r_d    = r_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = done_q;

    if (clr) begin
      a_sh_d = '0;
      acc_d  = '0;
      cnt_d  = '0;
      r_d    = '0;
      busy_d = 1'b0;
      done_d = 1'b0;
    end else if (start) begin
      a_sh_d = bus.a_in;
      b_d    = bus.b_in;
      m_d    = bus.m_in;
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
      done_d = 1'b0;
    end else if (bus.ena) begin
      case (state_q)
        CALC: begin
          acc_d  = (WIDTH + 1)'(u >> 1);
          a_sh_d = a_sh_q >> 1;
          cnt_d  = cnt_q + CW'(1);
        end
        FINAL: begin
          r_d    = (acc_q >= {1'b0, m_q}) ? WIDTH'(red) : WIDTH'(acc_q);
          busy_d = 1'b0;
          done_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.r_out = r_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_mmm_serial.sv
// Bench for mmm_serial: constant vectors, exhaustive M=13 sweep, random operands, control corners.
module tb_mmm_serial;
  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  mmm_serial_if #(.WIDTH(8)) bus ();
  mmm_serial #(.WIDTH(8)) dut (.clk(clk), .rstb(rstb), .bus(bus.slave));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] m;
    logic [7:0] exp;
  } vec_t;

  int nchk = 0;
  int nerr = 0;
  int exp_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Solve r*2^8 == a*b (mod m) by search, independent of the shift-add algorithm.
  function automatic int model(input int a, input int b, input int m);
    int p;
    p = (a * b) % m;
    for (int r = 0; r < m; r++)
      if (((r * 256) % m) == p) return r;
    return -1;
  endfunction

  task automatic start(input int a, input int b, input int m, input bit push, input int exp);
    bus.a_in = 8'(a);
    bus.b_in = 8'(b);
    bus.m_in = 8'(m);
    bus.ld_a = 1'b1;
    tick();
    bus.ld_a = 1'b0;
    if (push) exp_q.push_back(exp);
    chk("busy_after_start", int'(bus.busy), 1);
    chk("done_after_start", int'(bus.done), 0);
  endtask

  task automatic wait_done(input int exp_lat, input int m, input bit rng);
    int e;
    bit gap;
    e = 0;
    gap = 1'b0;
    while (e < 60) begin
      tick();
      e++;
      if (bus.done) break;
      if (!bus.busy) gap = 1'b1;
    end
    chk("latency", e, exp_lat);
    chk("busy_gap", int'(gap), 0);
    chk("busy_end", int'(bus.busy), 0);
    if (exp_q.size() == 0) begin
      nchk++;
      nerr++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else
      chk("result", int'(bus.r_out), exp_q.pop_front());
    if (rng) chk("range", int'(bus.r_out < 8'(m)), 1);
  endtask

  vec_t tbl[5];
  int ra, rb, rm;
  logic [7:0] hold_r;
  bit hold_bad;

  initial begin
    tbl[0] = '{8'd5,  8'd7,  8'd13,  8'd1};
    tbl[1] = '{8'd12, 8'd12, 8'd13,  8'd3};
    tbl[2] = '{8'd0,  8'd9,  8'd13,  8'd0};
    tbl[3] = '{8'd9,  8'd9,  8'd13,  8'd9};
    tbl[4] = '{8'd5,  8'd5,  8'd251, 8'd5};

    rstb = 1'b0;
    bus.ena = 1'b1;
    bus.rst_mmm = 1'b1;
    bus.ld_a = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.m_in = '0;
    #12;
    chk("rst_r_out", int'(bus.r_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    @(posedge clk);
    #1 rstb = 1'b1;
    repeat (3) tick();
    chk("idle_busy", int'(bus.busy), 0);

    for (int i = 0; i < 5; i++) begin
      start(tbl[i].a, tbl[i].b, tbl[i].m, 1'b1, int'(tbl[i].exp));
      wait_done(9, tbl[i].m, 1'b1);
    end

    for (int a = 0; a < 13; a++)
      for (int b = 0; b < 13; b++) begin
        start(a, b, 13, 1'b1, model(a, b, 13));
        wait_done(9, 13, 1'b1);
      end

    for (int i = 0; i < 10; i++) begin
      rm = $urandom_range(1, 127) * 2 + 1;
      ra = $urandom_range(0, rm - 1);
      rb = $urandom_range(0, rm - 1);
      start(ra, rb, rm, 1'b1, model(ra, rb, rm));
      wait_done(9, rm, 1'b1);
    end

    // Async reset mid-CALC while r_out still holds the previous result.
    start(5, 7, 13, 1'b1, 1);
    wait_done(9, 13, 1'b0);
    start(12, 12, 13, 1'b0, 0);
    repeat (3) tick();
    #2 rstb = 1'b0;
    #1;
    chk("midcalc_rst_r_out", int'(bus.r_out), 0);
    chk("midcalc_rst_busy", int'(bus.busy), 0);
    chk("midcalc_rst_done", int'(bus.done), 0);
    #3 rstb = 1'b1;
    repeat (12) tick();
    chk("post_rst_busy", int'(bus.busy), 0);
    chk("post_rst_done", int'(bus.done), 0);

    // Restart at edge 4; only the second operation completes.
    start(5, 7, 13, 1'b0, 0);
    hold_bad = 1'b0;
    repeat (3) begin
      tick();
      if (bus.done) hold_bad = 1'b1;
    end
    chk("restart_no_early_done", int'(hold_bad), 0);
    start(12, 12, 13, 1'b1, 3);
    wait_done(9, 13, 1'b1);

    // rst_mmm beats ld_a.
    bus.rst_mmm = 1'b0;
    bus.ld_a = 1'b1;
    bus.a_in = 8'd5;
    bus.b_in = 8'd7;
    bus.m_in = 8'd13;
    tick();
    bus.ld_a = 1'b0;
    bus.rst_mmm = 1'b1;
    chk("clr_r_out", int'(bus.r_out), 0);
    chk("clr_busy", int'(bus.busy), 0);
    chk("clr_done", int'(bus.done), 0);
    repeat (12) tick();
    chk("clr_stays_idle", int'(bus.done | bus.busy), 0);

    // Three disabled cycles mid-CALC stretch latency by three.
    start(11, 6, 13, 1'b1, model(11, 6, 13));
    repeat (3) tick();
    bus.ena = 1'b0;
    bus.ld_a = 1'b1;
    bus.rst_mmm = 1'b0;
    repeat (3) tick();
    bus.ena = 1'b1;
    bus.ld_a = 1'b0;
    bus.rst_mmm = 1'b1;
    wait_done(6, 13, 1'b1);

    // Hold after done, then ld_a clears done on its edge.
    hold_r = bus.r_out;
    hold_bad = 1'b0;
    repeat (20) begin
      tick();
      if (bus.r_out !== hold_r || bus.done !== 1'b1) hold_bad = 1'b1;
    end
    chk("hold_stable", int'(hold_bad), 0);
    start(9, 9, 13, 1'b1, 9);
    wait_done(9, 13, 1'b1);

    // Back-to-back start on the edge right after done.
    start(3, 4, 13, 1'b1, model(3, 4, 13));
    wait_done(9, 13, 1'b1);
    start(7, 8, 13, 1'b1, model(7, 8, 13));
    wait_done(9, 13, 1'b1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
